// File: rtl/vend_pkg.sv
// Shared types for the vending controller: coin codes, coin values, FSM states
// and the coin-code to value lookup.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_10  = 2'b00,
    COIN_20  = 2'b01,
    COIN_50  = 2'b10,
    COIN_BAD = 2'b11
  } coin_e;

  localparam int VAL_10 = 1;
  localparam int VAL_20 = 2;
  localparam int VAL_50 = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CREDIT = 2'b01,
    S_VEND   = 2'b10,
    S_CHANGE = 2'b11
  } state_e;

  function automatic logic [2:0] coin_value(input coin_e c);
    case (c)
      COIN_10: return 3'(VAL_10);
      COIN_20: return 3'(VAL_20);
      COIN_50: return 3'(VAL_50);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_fsm_multi_if.sv
// Front-end / dispenser signal bundle of the vending controller.
// master = keypad, coin acceptor and change dispenser side; slave = controller.
interface vend_fsm_multi_if #(
  parameter int SEL_W = 2,
  parameter int AMT_W = 8
);
  logic             coin_valid;
  logic [1:0]       coin;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             cancel;
  logic             coin_accept;
  logic             coin_reject;
  logic             sel_err;
  logic             vend;
  logic [SEL_W-1:0] vend_id;
  logic [AMT_W-1:0] credit;
  logic             change_valid;
  logic [1:0]       change_coin;
  logic             change_ready;
  logic             busy;

  modport master (
    output coin_valid, coin, sel_valid, sel, cancel, change_ready,
    input  coin_accept, coin_reject, sel_err, vend, vend_id, credit,
           change_valid, change_coin, busy
  );

  modport slave (
    input  coin_valid, coin, sel_valid, sel, cancel, change_ready,
    output coin_accept, coin_reject, sel_err, vend, vend_id, credit,
           change_valid, change_coin, busy
  );
endinterface

// File: rtl/vend_change_gen.sv
// Greedy change picker: the largest coin not exceeding the remaining credit.
// Credit 0 yields value 0; the controller never offers change then.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] credit,
  output coin_e            coin,
  output logic [AMT_W-1:0] value
);

  always_comb begin
    coin  = COIN_10;
    value = '0;
    if (credit >= AMT_W'(VAL_50)) begin
      coin  = COIN_50;
      value = AMT_W'(VAL_50);
    end else if (credit >= AMT_W'(VAL_20)) begin
      coin  = COIN_20;
      value = AMT_W'(VAL_20);
    end else if (credit != '0) begin
      coin  = COIN_10;
      value = AMT_W'(VAL_10);
    end
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller: credit accumulation, priced vend,
// cancel/refund and coin-by-coin change over a ready/valid stream.
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int                        N_PROD     = 4,
  parameter int                        AMT_W      = 8,
  parameter logic [N_PROD*AMT_W-1:0]   PRICES     = {8'd8, 8'd6, 8'd5, 8'd4},
  parameter int                        MAX_CREDIT = 20,
  parameter int                        SEL_W      = 2
) (
  input logic              clk,
  input logic              reset,
  vend_fsm_multi_if.slave  bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0] vend_id_q, vend_id_d;
  logic             coin_accept_q, coin_accept_d;
  logic             coin_reject_q, coin_reject_d;
  logic             sel_err_q, sel_err_d;

  logic             coin_ok;
  logic [AMT_W-1:0] coin_val;
  logic [AMT_W:0]   credit_sum;
  logic [AMT_W-1:0] price;
  logic             sel_ok;
  coin_e            chg_coin;
  logic [AMT_W-1:0] chg_value;

  assign coin_ok    = (coin_e'(bus.coin) != COIN_BAD);
  assign coin_val   = AMT_W'(coin_value(coin_e'(bus.coin)));
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};

  // Indices at or beyond N_PROD leave sel_ok low and are refused.
  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        price  = PRICES[i*AMT_W +: AMT_W];
        sel_ok = 1'b1;
      end
    end
  end

  vend_change_gen #(.AMT_W(AMT_W)) u_change_gen (
    .credit (credit_q),
    .coin   (chg_coin),
    .value  (chg_value)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    coin_accept_d = 1'b0;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d      = coin_val;
            coin_accept_d = 1'b1;
            state_d       = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        sel_err_d = bus.sel_valid;
      end
      S_CREDIT: begin
        if (bus.cancel) begin
          state_d = S_CHANGE;
        end else if (bus.sel_valid) begin
          if (sel_ok && credit_q >= price) begin
            credit_d  = credit_q - price;
            vend_id_d = bus.sel;
            state_d   = S_VEND;
          end else begin
            sel_err_d = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok && credit_sum <= (AMT_W+1)'(MAX_CREDIT)) begin
            credit_d      = credit_sum[AMT_W-1:0];
            coin_accept_d = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        // A coin arriving alongside a cancel or selection is handed back.
        if (bus.coin_valid && (bus.cancel || bus.sel_valid)) coin_reject_d = 1'b1;
      end
      S_VEND: begin
        state_d       = (credit_q == '0) ? S_IDLE : S_CHANGE;
        coin_reject_d = bus.coin_valid;
        sel_err_d     = bus.sel_valid;
      end
      S_CHANGE: begin
        if (bus.change_ready) begin
          credit_d = credit_q - chg_value;
          if (credit_q == chg_value) state_d = S_IDLE;
        end
        coin_reject_d = bus.coin_valid;
        sel_err_d     = bus.sel_valid;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      vend_id_q     <= '0;
      coin_accept_q <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_id_q     <= vend_id_d;
      coin_accept_q <= coin_accept_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bus.coin_accept  = coin_accept_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sel_err      = sel_err_q;
  assign bus.vend         = (state_q == S_VEND);
  assign bus.vend_id      = vend_id_q;
  assign bus.credit       = credit_q;
  assign bus.change_valid = (state_q == S_CHANGE);
  assign bus.change_coin  = (state_q == S_CHANGE) ? chg_coin : COIN_10;
  assign bus.busy         = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: doc/vend_fsm_multi.md
# vend_fsm_multi

Parametrised multi-product vending controller: next generation of the team's single-price coin FSM. Accumulates credit from 10/20/50 coins with a valid strobe, vends one of `N_PROD` products at per-product prices, and supports cancel/refund. Change is returned as a coin-by-coin ready/valid stream to the dispenser. It sits between the coin acceptor / keypad front-end and the product and change actuators.

## Interface
All amounts are in units of 10 (coin 10 = 1, 20 = 2, 50 = 5).
- `N_PROD`, default 4: number of selectable products.
- `AMT_W`, default 8: width of the credit and price fields.
- `PRICES`, default {8,6,5,4}: packed `N_PROD*AMT_W` vector; product i occupies bits `[i*AMT_W +: AMT_W]`. Every price must be ≥1.
- `MAX_CREDIT`, default 20: credit ceiling. Must be < 2^AMT_W − 5.
- `SEL_W`, default 2: width of `sel`; equals `$clog2(N_PROD)`, with a minimum of 1.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `coin_valid` in 1: a coin is presented this cycle.
- `coin` in 2: coin code. 00 = 10, 01 = 20, 10 = 50, 11 = invalid.
- `sel_valid` in 1: a product-selection strobe.
- `sel` in SEL_W: product index.
- `cancel` in 1: refund request.
- `coin_accept` out 1: one-cycle pulse, coin taken.
- `coin_reject` out 1: one-cycle pulse, coin returned.
- `sel_err` out 1: one-cycle pulse, selection refused.
- `vend` out 1: one-cycle pulse, release product.
- `vend_id` out SEL_W: product being released; valid while `vend` = 1.
- `credit` out AMT_W: current credit, registered.
- `change_valid` out 1: a change coin is offered.
- `change_coin` out 2: code of the offered coin, same encoding as `coin`.
- `change_ready` in 1: the dispenser takes the offered coin.
- `busy` out 1: high in VEND or CHANGE.

## Operation
- States are IDLE, CREDIT, VEND and CHANGE.
- **Reset:** state = IDLE and credit = 0. Every output is 0, including `vend_id` and `change_coin`.
- **IDLE:** a valid coin sets credit to the coin value, pulses `coin_accept`, and moves to CREDIT. An invalid code pulses `coin_reject`. `sel_valid` pulses `sel_err`. `cancel` is ignored.
- **CREDIT** uses a fixed priority of cancel > sel > coin:
  - `cancel` moves to CHANGE.
  - Otherwise `sel_valid`:
    - If `sel` < N_PROD and credit ≥ PRICES[sel]: credit −= price, latch `vend_id`, move to VEND.
    - Else pulse `sel_err` and stay in CREDIT.
  - Otherwise a coin:
    - Accepted when the code is valid and credit + value ≤ MAX_CREDIT.
    - Otherwise `coin_reject`.
  - Any coin presented in the same cycle as an acted-on `cancel` or `sel_valid` gets `coin_reject`.
- **VEND:** lasts exactly one cycle with `vend` = 1. Then go to IDLE if credit = 0, else to CHANGE.
- **CHANGE:**
  - `change_valid` = 1 throughout the state.
  - `change_coin` is the greedy largest coin ≤ credit (50, then 20, then 10).
  - On `change_valid && change_ready`, credit −= the coin value. If the result is 0, go to IDLE next cycle.
  - Any coin is rejected. `sel_valid` gives `sel_err`. `cancel` is ignored.
- Credit never underflows or exceeds MAX_CREDIT. All arithmetic is unsigned AMT_W with one guard bit on the add.

## Timing
- `coin_accept`, `coin_reject`, `sel_err` and `credit` update on the edge that samples the input, so they are visible in cycle N+1 for an input in cycle N.
- `vend` and `busy` are Moore outputs decoded from state. `vend` is high in the cycle after the accepted `sel_valid`.
- `change_valid` and `change_coin` are Moore outputs from the state and credit registers. They must be stable while `change_ready` = 0. The dispenser may stall indefinitely.
- There is one handshake per cycle at most. Back-to-back coins are possible with `change_ready` held high.
- Minimum transaction latency: a vend with exact credit returns to IDLE 2 cycles after `sel_valid`.
- `reset` mid-VEND or mid-CHANGE clears state on the next edge. The credit is forfeited and no further change is offered.

## Structure
- Shared package `vend_pkg` holds:
  - Coin codes `COIN_10`, `COIN_20`, `COIN_50`, `COIN_BAD`.
  - Coin values 1, 2 and 5.
  - State encodings.
  - A `coin_value()` function.
- Sub-module `vend_change_gen`: combinational greedy coin pick from credit, exposing `coin` and `value`. It is instantiated once.
- The top level holds the FSM, the credit register, price indexing and the pulse registers.

## Test plan
- Reset, coins 20,20, `sel` = 0 (price 4) → `vend` = 1 with `vend_id` = 0 for one cycle, no `change_valid`, back to IDLE, credit 0.
- Coins 50,20 (credit 7), `sel` = 1 (price 5) → `vend`; CHANGE offers 20 once; after the handshake credit = 0 and the block is in IDLE.
- Coins 50,20,10 (credit 8), then `cancel` with `change_ready` = 0 for 3 cycles → `change_coin` holds 50; then 50, 20, 10 are dispensed in order.
- Four coins of 50 (credit 20), then a fifth 50 → `coin_reject` and credit stays 20. Code 11 in IDLE → `coin_reject`.
- Credit 2, `sel` = 3 (price 8) → `sel_err` and credit unchanged. In the same test, `sel` and coin in one cycle with enough credit → vend plus `coin_reject`.
- `reset` asserted during CHANGE with credit 3 → next cycle IDLE, credit 0, all outputs 0.
